// File: rtl/stride_top.sv
// Stride value predictor: tagged table of {last, stride, conf} entries.
// Forward lanes look up last+stride by PC, and feedback lanes train the
// table and flag confident mispredictions. Both paths have a two-edge latency.
module stride_top #(
    parameter int unsigned P_STORAGE_SIZE = 1024,
    parameter int unsigned P_DATA_WIDTH   = 32,
    parameter int unsigned P_TAG_WIDTH    = 8,
    parameter int unsigned P_CONF_WIDTH   = 2,
    parameter int unsigned P_CONF_THRES   = 3,
    parameter int unsigned P_NUM_PRED     = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic [P_NUM_PRED-1:0]                   fw_valid_i,
    input  logic [P_NUM_PRED-1:0][31:0]             fw_pc_i,
    output logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0] pred_o,
    output logic [P_NUM_PRED-1:0]                   pred_valid_o,
    input  logic [P_NUM_PRED-1:0]                   fb_valid_i,
    input  logic [P_NUM_PRED-1:0][31:0]             fb_pc_i,
    input  logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0] fb_result_i,
    output logic [P_NUM_PRED-1:0]                   mispredict_o
);

    localparam int unsigned P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
    localparam int unsigned IDX_LSB       = 2;
    localparam int unsigned TAG_LSB       = IDX_LSB + P_INDEX_WIDTH;

    typedef logic [P_INDEX_WIDTH-1:0] idx_t;
    typedef logic [P_TAG_WIDTH-1:0]   tag_t;
    typedef logic [P_DATA_WIDTH-1:0]  data_t;
    typedef logic [P_CONF_WIDTH-1:0]  conf_t;

    typedef struct packed {
        tag_t  tag;
        data_t last;
        data_t stride;
        conf_t conf;
    } entry_t;

    localparam conf_t CONF_MAX = {P_CONF_WIDTH{1'b1}};
    localparam conf_t CONF_THR = P_CONF_WIDTH'(P_CONF_THRES);
    localparam conf_t CONF_ONE = P_CONF_WIDTH'(1);

    // Table storage: valid bits are reset, payload is not
    logic [P_STORAGE_SIZE-1:0] valid_q;
    entry_t                    mem_q [P_STORAGE_SIZE];

    // d1 stage registers
    logic [P_NUM_PRED-1:0] fw_valid_d1;
    idx_t                  fw_idx_d1    [P_NUM_PRED];
    tag_t                  fw_tag_d1    [P_NUM_PRED];
    logic [P_NUM_PRED-1:0] fb_valid_d1;
    idx_t                  fb_idx_d1    [P_NUM_PRED];
    tag_t                  fb_tag_d1    [P_NUM_PRED];
    data_t                 fb_result_d1 [P_NUM_PRED];

    // d1 combinational results
    entry_t                fb_rd_c      [P_NUM_PRED];
    data_t                 fb_delta_c   [P_NUM_PRED];
    logic [P_NUM_PRED-1:0] fb_hit_c;
    entry_t                fb_new_c     [P_NUM_PRED];
    logic [P_NUM_PRED-1:0] fb_mis_c;
    logic [P_NUM_PRED-1:0] fb_commit_c;
    entry_t                fw_rd_c      [P_NUM_PRED];
    logic [P_NUM_PRED-1:0] fw_hit_c;

    // Only index and tag bits of the PC matter; the rest is deliberately dropped
    logic unused_pc;
    assign unused_pc = ^{fw_pc_i, fb_pc_i};

    // Register forward and feedback requests into d1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fw_valid_d1 <= '0;
            fb_valid_d1 <= '0;
            for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
                fw_idx_d1[i]    <= '0;
                fw_tag_d1[i]    <= '0;
                fb_idx_d1[i]    <= '0;
                fb_tag_d1[i]    <= '0;
                fb_result_d1[i] <= '0;
            end
        end else begin
            fw_valid_d1 <= fw_valid_i;
            fb_valid_d1 <= fb_valid_i;
            for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
                fw_idx_d1[i]    <= fw_pc_i[i][IDX_LSB +: P_INDEX_WIDTH];
                fw_tag_d1[i]    <= fw_pc_i[i][TAG_LSB +: P_TAG_WIDTH];
                fb_idx_d1[i]    <= fb_pc_i[i][IDX_LSB +: P_INDEX_WIDTH];
                fb_tag_d1[i]    <= fb_pc_i[i][TAG_LSB +: P_TAG_WIDTH];
                fb_result_d1[i] <= fb_result_i[i];
            end
        end
    end

    // Feedback lookup against the pre-update table
    always_comb begin
        for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
            fb_rd_c[i]    = mem_q[fb_idx_d1[i]];
            fb_hit_c[i]   = valid_q[fb_idx_d1[i]] && (fb_rd_c[i].tag == fb_tag_d1[i]);
            fb_delta_c[i] = fb_result_d1[i] - fb_rd_c[i].last;
        end
    end

    // Trained entry and mispredict flag per feedback lane
    always_comb begin
        for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
            fb_new_c[i].tag    = fb_tag_d1[i];
            fb_new_c[i].last   = fb_result_d1[i];
            fb_new_c[i].stride = '0;
            fb_new_c[i].conf   = '0;
            if (fb_hit_c[i]) begin
                if (fb_delta_c[i] == fb_rd_c[i].stride) begin
                    fb_new_c[i].stride = fb_rd_c[i].stride;
                    fb_new_c[i].conf   = (fb_rd_c[i].conf == CONF_MAX) ? CONF_MAX
                                                                       : fb_rd_c[i].conf + CONF_ONE;
                end else begin
                    fb_new_c[i].stride = fb_delta_c[i];
                end
            end
            // last + stride != result is the same test as delta != stride (mod 2^W)
            fb_mis_c[i] = fb_valid_d1[i] && !flush_i && fb_hit_c[i]
                       && (fb_rd_c[i].conf >= CONF_THR)
                       && (fb_delta_c[i] != fb_rd_c[i].stride);
        end
    end

    // A lane commits unless a higher lane writes the same index or a flush is in progress
    always_comb begin
        for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
            fb_commit_c[i] = fb_valid_d1[i] && !flush_i;
            for (int unsigned j = i + 1; j < P_NUM_PRED; j++) begin
                if (fb_valid_d1[j] && (fb_idx_d1[j] == fb_idx_d1[i])) begin
                    fb_commit_c[i] = 1'b0;
                end
            end
        end
    end

    // Forward lookup with write-first bypass from committing feedback
    always_comb begin
        for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
            fw_rd_c[i]  = mem_q[fw_idx_d1[i]];
            fw_hit_c[i] = valid_q[fw_idx_d1[i]];
            for (int unsigned j = 0; j < P_NUM_PRED; j++) begin
                if (fb_commit_c[j] && (fb_idx_d1[j] == fw_idx_d1[i])) begin
                    fw_rd_c[i]  = fb_new_c[j];
                    fw_hit_c[i] = 1'b1;
                end
            end
            fw_hit_c[i] = fw_hit_c[i] && (fw_rd_c[i].tag == fw_tag_d1[i]);
        end
    end

    // Registered prediction and mispredict outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_o       <= '0;
            pred_valid_o <= '0;
            mispredict_o <= '0;
        end else begin
            for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
                pred_o[i]       <= fw_hit_c[i] ? (fw_rd_c[i].last + fw_rd_c[i].stride) : '0;
                pred_valid_o[i] <= fw_valid_d1[i] && !flush_i && fw_hit_c[i]
                                && (fw_rd_c[i].conf >= CONF_THR);
            end
            mispredict_o <= fb_mis_c;
        end
    end

    // Valid bits: flush clears everything, otherwise commits allocate
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
                if (fb_commit_c[i]) begin
                    valid_q[fb_idx_d1[i]] <= 1'b1;
                end
            end
        end
    end

    // Entry payload writes from winning feedback lanes
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
            if (fb_commit_c[i]) begin
                mem_q[fb_idx_d1[i]] <= fb_new_c[i];
            end
        end
    end

endmodule

// File: tb/tb_stride_top.sv
// Bench for stride_top: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a table-level model.
module tb_stride_top;

    localparam int N = 2;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                flush_i;
    logic [N-1:0]        fw_valid_i;
    logic [N-1:0][31:0]  fw_pc_i;
    logic [N-1:0][31:0]  pred_o;
    logic [N-1:0]        pred_valid_o;
    logic [N-1:0]        fb_valid_i;
    logic [N-1:0][31:0]  fb_pc_i;
    logic [N-1:0][31:0]  fb_result_i;
    logic [N-1:0]        mispredict_o;

    int n_chk  = 0;
    int n_pass = 0;
    bit seen;

    stride_top dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fw_valid_i   (fw_valid_i),
        .fw_pc_i      (fw_pc_i),
        .pred_o       (pred_o),
        .pred_valid_o (pred_valid_o),
        .fb_valid_i   (fb_valid_i),
        .fb_pc_i      (fb_pc_i),
        .fb_result_i  (fb_result_i),
        .mispredict_o (mispredict_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                      name, got, got, exp, exp, $time);
    endtask

    // ---------------- reference model: the table as plain arrays ----------------
    bit          m_v      [1024];
    logic [7:0]  m_tag    [1024];
    logic [31:0] m_last   [1024];
    logic [31:0] m_stride [1024];
    int          m_conf   [1024];

    bit          d_fwv [N];
    logic [31:0] d_fwpc[N];
    bit          d_fbv [N];
    logic [31:0] d_fbpc[N];
    logic [31:0] d_fbres[N];

    bit          e_fwv [N];
    logic [31:0] e_pred[N];
    bit          e_pv  [N];
    bit          e_mis [N];

    function automatic int ix(input logic [31:0] pc);
        return int'(pc[11:2]);
    endfunction

    function automatic logic [7:0] tg(input logic [31:0] pc);
        return pc[19:12];
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        return m_v[ix(pc)] && (m_tag[ix(pc)] == tg(pc));
    endfunction

    // Each edge retires the batch captured at the previous edge
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            foreach (m_v[k]) m_v[k] = 1'b0;
            for (int i = 0; i < N; i++) begin
                d_fwv[i] = 1'b0; d_fbv[i] = 1'b0;
                e_fwv[i] = 1'b0; e_pv[i] = 1'b0; e_mis[i] = 1'b0; e_pred[i] = '0;
            end
        end else begin
            logic [31:0] nl[N];
            logic [31:0] ns[N];
            int          nc[N];
            int          k;
            bit          h;
            // outcome of every feedback from the table as it was before this edge
            for (int i = 0; i < N; i++) begin
                k = ix(d_fbpc[i]);
                h = d_fbv[i] && mhit(d_fbpc[i]);
                e_mis[i] = h && !flush_i && (m_conf[k] >= 3)
                        && ((m_last[k] + m_stride[k]) != d_fbres[i]);
                nl[i] = d_fbres[i];
                ns[i] = '0;
                nc[i] = 0;
                if (h) begin
                    if ((d_fbres[i] - m_last[k]) == m_stride[k]) begin
                        ns[i] = m_stride[k];
                        nc[i] = (m_conf[k] < 3) ? m_conf[k] + 1 : 3;
                    end else begin
                        ns[i] = d_fbres[i] - m_last[k];
                    end
                end
            end
            // write in lane order, so the highest lane overwrites
            if (!flush_i) begin
                for (int i = 0; i < N; i++) begin
                    if (d_fbv[i]) begin
                        k = ix(d_fbpc[i]);
                        m_v[k] = 1'b1; m_tag[k] = tg(d_fbpc[i]);
                        m_last[k] = nl[i]; m_stride[k] = ns[i]; m_conf[k] = nc[i];
                    end
                end
            end
            // forwards read after the writes (write-first)
            for (int i = 0; i < N; i++) begin
                k = ix(d_fwpc[i]);
                h = mhit(d_fwpc[i]);
                e_fwv[i]  = d_fwv[i];
                e_pred[i] = h ? (m_last[k] + m_stride[k]) : 32'd0;
                e_pv[i]   = d_fwv[i] && h && !flush_i && (m_conf[k] >= 3);
            end
            if (flush_i) foreach (m_v[j]) m_v[j] = 1'b0;
            for (int i = 0; i < N; i++) begin
                d_fwv[i]   = fw_valid_i[i];
                d_fwpc[i]  = fw_pc_i[i];
                d_fbv[i]   = fb_valid_i[i];
                d_fbpc[i]  = fb_pc_i[i];
                d_fbres[i] = fb_result_i[i];
            end
        end
    end

    // Compare DUT outputs with the model mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("model pred_valid[%0d]", i), 32'(pred_valid_o[i]), 32'(e_pv[i]));
            chk($sformatf("model mispredict[%0d]", i), 32'(mispredict_o[i]), 32'(e_mis[i]));
            if (e_fwv[i]) chk($sformatf("model pred[%0d]", i), pred_o[i], e_pred[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] pool[8] = '{32'h40, 32'hC0, 32'h80, 32'h1040,
                             32'h200, 32'h204, 32'h3FFC, 32'h7FF0_0100};
    logic [31:0] gval[8];
    logic [31:0] gstr[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        fw_valid_i = '0;
        fb_valid_i = '0;
        flush_i    = 1'b0;
    endtask

    task automatic fb(input int lane, input logic [31:0] pc, input logic [31:0] res);
        fb_valid_i[lane]  = 1'b1;
        fb_pc_i[lane]     = pc;
        fb_result_i[lane] = res;
    endtask

    task automatic fw(input int lane, input logic [31:0] pc);
        fw_valid_i[lane] = 1'b1;
        fw_pc_i[lane]    = pc;
    endtask

    // One feedback per cycle forming an arithmetic sequence
    task automatic train(input int lane, input logic [31:0] pc, input logic [31:0] start,
                         input logic [31:0] step, input int n);
        for (int k = 0; k < n; k++) begin
            clr();
            fb(lane, pc, start + step * 32'(k));
            tick();
        end
    endtask

    // Forward request, then wait until its result is on the outputs
    task automatic probe(input int lane, input logic [31:0] pc);
        clr();
        fw(lane, pc);
        tick();
        clr();
        tick();
    endtask

    task automatic rand_cycle();
        int k;
        clr();
        flush_i = ($urandom_range(0, 199) == 0);
        for (int i = 0; i < N; i++) begin
            fw_valid_i[i] = ($urandom_range(0, 1) == 1);
            k = int'($urandom_range(0, 7));
            fw_pc_i[i] = pool[k];
            fb_valid_i[i] = ($urandom_range(0, 2) != 0);
            k = int'($urandom_range(0, 7));
            fb_pc_i[i] = pool[k];
            fb_result_i[i] = gval[k];
            if (fb_valid_i[i]) begin
                gval[k] = gval[k] + gstr[k];
                if ($urandom_range(0, 19) == 0) gstr[k] = $urandom_range(0, 9);
                if ($urandom_range(0, 39) == 0) gval[k] = $urandom;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_ni = 1'b0;
        clr();
        fw_pc_i = '0; fb_pc_i = '0; fb_result_i = '0;
        for (int k = 0; k < 8; k++) begin
            gval[k] = 32'(k * 1000);
            gstr[k] = 32'(k);
        end
        gval[6] = 32'hFFFF_FFF0;
        gstr[6] = 32'd7;

        repeat (3) @(posedge clk);
        #1;
        chk("reset pred_valid", 32'(pred_valid_o), 32'd0);
        chk("reset mispredict", 32'(mispredict_o), 32'd0);
        chk("reset pred0", pred_o[0], 32'd0);
        chk("reset pred1", pred_o[1], 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        // stride training
        train(0, 32'h40, 32'd100, 32'd4, 3);
        probe(0, 32'h40);
        chk("early pred_valid", 32'(pred_valid_o[0]), 32'd0);
        chk("early pred", pred_o[0], 32'd112);
        train(0, 32'h40, 32'd112, 32'd4, 2);
        probe(0, 32'h40);
        chk("trained pred_valid", 32'(pred_valid_o[0]), 32'd1);
        chk("trained pred", pred_o[0], 32'd120);

        // mispredict then retrained stride
        clr(); fb(0, 32'h40, 32'd200); tick();
        clr(); tick();
        chk("mispredict pulse", 32'(mispredict_o[0]), 32'd1);
        tick();
        chk("mispredict end", 32'(mispredict_o[0]), 32'd0);
        probe(0, 32'h40);
        chk("post-mis pred_valid", 32'(pred_valid_o[0]), 32'd0);
        chk("post-mis pred", pred_o[0], 32'd284);

        // tag alias reallocates
        train(0, 32'h40, 32'd204, 32'd4, 4);
        probe(0, 32'h40);
        chk("retrain pred", pred_o[0], 32'd220);
        chk("retrain pred_valid", 32'(pred_valid_o[0]), 32'd1);
        clr(); fb(0, 32'h1040, 32'd7); tick();
        clr(); tick();
        chk("alias no mispredict", 32'(mispredict_o[0]), 32'd0);
        probe(0, 32'h40);
        chk("alias pred_valid", 32'(pred_valid_o[0]), 32'd0);
        chk("alias pred", pred_o[0], 32'd0);

        // lane conflict: lane 1 wins
        clr(); fb(0, 32'h80, 32'd5); fb(1, 32'h80, 32'd9); tick();
        clr(); fw(1, 32'h80); tick();
        clr(); tick();
        chk("conflict pred", pred_o[1], 32'd9);
        chk("conflict pred_valid", 32'(pred_valid_o[1]), 32'd0);

        // same-cycle bypass
        train(1, 32'hC0, 32'd10, 32'd10, 4);
        clr(); fb(1, 32'hC0, 32'd50); fw(0, 32'hC0); tick();
        clr(); tick();
        chk("bypass pred_valid", 32'(pred_valid_o[0]), 32'd1);
        chk("bypass pred", pred_o[0], 32'd60);

        // flush suppresses mispredict and invalidates entries
        train(0, 32'h200, 32'd1, 32'd1, 5);
        clr(); fb(0, 32'h200, 32'd99); tick();
        clr(); flush_i = 1'b1; tick();
        chk("flush mispredict", 32'(mispredict_o[0]), 32'd0);
        clr(); fw(0, 32'hC0); fw(1, 32'h200); tick();
        clr(); tick();
        chk("flush pred_valid", 32'(pred_valid_o), 32'd0);
        chk("flush pred0", pred_o[0], 32'd0);
        chk("flush pred1", pred_o[1], 32'd0);

        // randomized traffic
        repeat (1500) begin rand_cycle(); tick(); end

        // async reset while a prediction is on the outputs
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            rand_cycle();
            tick();
            if (|pred_valid_o) seen = 1'b1;
        end
        chk("reset hunt budget", 32'(seen), 32'd1);
        @(negedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async pred_valid", 32'(pred_valid_o), 32'd0);
        chk("async mispredict", 32'(mispredict_o), 32'd0);
        chk("async pred0", pred_o[0], 32'd0);
        chk("async pred1", pred_o[1], 32'd0);
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_ni = 1'b1;
        tick();
        clr(); fw(0, 32'hC0); fw(1, 32'h40); tick();
        clr(); tick();
        chk("post-reset pred_valid", 32'(pred_valid_o), 32'd0);
        chk("post-reset pred0", pred_o[0], 32'd0);

        repeat (1000) begin rand_cycle(); tick(); end
        clr();
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stride_top.md
# stride_top

Next-generation value predictor, the successor to the last-value predictor. Each entry is tagged and holds last value, stride and a saturating confidence counter. The prediction is `last + stride`, so constant sequences (stride 0) and arithmetic sequences are both covered. The block sits beside the decode/issue stage: the forward lanes request predictions by PC, and the feedback lanes return committed results that train the table and flag mispredictions.

## Interface
- `P_STORAGE_SIZE`, 1024: number of entries; power of two.
- `P_DATA_WIDTH`, 32: width of values and strides.
- `P_TAG_WIDTH`, 8: PC tag bits stored per entry. Requires `2 + P_INDEX_WIDTH + P_TAG_WIDTH <= 32`.
- `P_CONF_WIDTH`, 2: width of the confidence counter.
- `P_CONF_THRES`, 3: minimum confidence for a valid prediction. Must be between 1 and 2^P_CONF_WIDTH-1.
- `P_NUM_PRED`, 2: number of forward lanes and number of feedback lanes.
- `P_INDEX_WIDTH` (localparam): `$clog2(P_STORAGE_SIZE)`.
- `clk_i`, input, 1: the single clock.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `flush_i`, input, 1: synchronous invalidate of all entries.
- `fw_valid_i`, input, [P_NUM_PRED]: forward request qualifier.
- `fw_pc_i`, input, [P_NUM_PRED][32]: PC to predict.
- `pred_o`, output, [P_NUM_PRED][P_DATA_WIDTH]: predicted value.
- `pred_valid_o`, output, [P_NUM_PRED]: qualifies `pred_o`.
- `fb_valid_i`, input, [P_NUM_PRED]: feedback qualifier.
- `fb_pc_i`, input, [P_NUM_PRED][32]: PC of the committed instruction.
- `fb_result_i`, input, [P_NUM_PRED][P_DATA_WIDTH]: true result.
- `mispredict_o`, output, [P_NUM_PRED]: the confident prediction for this feedback was wrong.

## Operation
- **PC decode**
  - index = `pc[P_INDEX_WIDTH+1:2]`.
  - tag = the next `P_TAG_WIDTH` bits above the index.
  - hit = entry valid and stored tag equals the PC tag.
- **Entry contents:** valid, tag, last, stride, conf.
  - Reset clears every valid bit asynchronously.
  - Data fields are not reset.
- **Forward path**
  - `fw_valid_i`/`fw_pc_i` are registered (fw stage d1).
  - In d1 the table is read.
  - `pred_o` is registered as `last + stride`, modulo 2^P_DATA_WIDTH.
  - `pred_valid_o` is registered as `fw_valid_d1 & hit & (conf >= P_CONF_THRES)`.
  - On a miss, `pred_o` = 0.
- **Feedback path**
  - Feedback inputs are registered (fb stage d1).
  - In d1, for each lane with `fb_valid_d1`, the entry is read and `delta = result - last` (mod 2^W).
  - Hit, `delta == stride`: conf saturating-increments; last = result.
  - Hit, `delta != stride`: conf = 0; stride = delta; last = result.
  - Miss (invalid entry or tag mismatch): allocate with valid=1, tag, last=result, stride=0, conf=0.
  - `mispredict_o` is registered as `fb_valid_d1 & hit & conf >= P_CONF_THRES & (last + stride != result)`, using pre-update entry state.
- **Lane conflict:** several feedback lanes with the same index in one cycle.
  - The highest-numbered lane's update commits; lower lanes' updates are dropped.
  - All lanes compute `mispredict_o` from the same pre-update state.
- **Write-first bypass:** a forward read in d1 whose index matches a committing feedback write sees the post-update entry. If several lanes write that index, it sees the winning lane's write.
- **flush_i**
  - At the next edge, all valid bits clear.
  - Feedback in d1 during the flush cycle is discarded: no commit, `mispredict_o` = 0.
  - Forward reads in d1 during the flush cycle produce `pred_valid_o` = 0.
  - Flush overrides any commit at that edge.

## Timing
- Values during `rst_ni` low: `pred_o` = 0, `pred_valid_o` = 0, `mispredict_o` = 0, all d1 valids = 0.
- Reset assertion mid-operation drops all in-flight requests and feedback immediately.
- Prediction latency is 2 edges: `fw_pc_i` presented in cycle t gives `pred_o`/`pred_valid_o` during cycle t+2.
- `pred_valid_o` is pulsed per request; there is no backpressure, so one request per lane per cycle is always accepted.
- Mispredict latency is 2 edges: feedback presented in cycle t gives `mispredict_o` during cycle t+2, a one-cycle pulse.
- The table update from cycle-t feedback commits at the end of cycle t+1.
- With bypass, a forward request in cycle t to the same PC as cycle-t feedback observes that update.
- Confidence saturates at 2^P_CONF_WIDTH-1 and never wraps.
- Value and stride arithmetic wraps modulo 2^P_DATA_WIDTH.

## Test plan
- **Stride training:** lane 0 feedback at PC 0x40 with results 100, 104, 108, 112, 116 on consecutive cycles, then forward PC 0x40 → `pred_o` = 120, `pred_valid_o` = 1. A forward PC 0x40 issued after only 100, 104, 108 → `pred_valid_o` = 0.
- **Mispredict and reset:** after the training above, feedback 200 at PC 0x40 → `mispredict_o[0]` pulses 2 cycles later; then forward PC 0x40 → `pred_valid_o` = 0 and `pred_o` = 284 (stride 84).
- **Tag alias:** train PC 0x40, then feedback at PC 0x40 + 4·P_STORAGE_SIZE → no mispredict and the entry is reallocated; forward PC 0x40 → `pred_valid_o` = 0.
- **Lane conflict:** both lanes feed back the same PC with results 5 (lane 0) and 9 (lane 1) → the stored last value is 9; forward of that PC the next cycle reflects last = 9.
- **Same-cycle bypass:** forward and feedback of the same PC in cycle t → `pred_o` in t+2 uses the post-update entry.
- **Flush and async reset:** after training, `flush_i` for one cycle → every entry misses afterwards. Asserting `rst_ni` low mid-stream → all outputs 0 asynchronously and all entries invalid.
